// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: TDC state encoding, magnitude width/limit and the
// lead polarity convention agreed with the loop filter.
package adpll_pkg;

    typedef enum logic [0:0] {
        TDC_IDLE  = 1'b0,
        TDC_COUNT = 1'b1
    } tdc_state_e;

    localparam int OUT_WIDTH_DEF = 8;
    localparam logic [OUT_WIDTH_DEF-1:0] MAG_MAX = {OUT_WIDTH_DEF{1'b1}};

    // lead = 1 means the feedback edge arrived before the reference edge
    localparam logic LEAD_FB  = 1'b1;
    localparam logic LEAD_REF = 1'b0;

endpackage

// File: rtl/phase_tdc_detector_if.sv
// Phase-error bus from the TDC to the loop filter: magnitude, direction and strobes.
interface phase_tdc_detector_if
    import adpll_pkg::*;
#(
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
);
    logic [OUT_WIDTH-1:0] master_out;
    logic                 lead;
    logic                 valid;
    logic                 slip;
    logic                 timeout;

    modport master (output master_out, lead, valid, slip, timeout);
    modport slave  (input  master_out, lead, valid, slip, timeout);
endinterface

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous clock input into the clk domain and emits a
// registered single-cycle pulse on each rising edge.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    // synchronizer chain, delayed copy and rising-edge pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/phase_tdc_detector.sv
// Counter-based phase detector: measures the clk-cycle distance between reference
// and feedback rising edges and reports saturated magnitude plus lead direction.
module phase_tdc_detector
    import adpll_pkg::*;
#(
    parameter int OUT_WIDTH      = OUT_WIDTH_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 ref_in,
    input  logic                 fb_in,
    phase_tdc_detector_if.master tdc
);

    localparam logic [0:0] S_IDLE  = TDC_IDLE;
    localparam logic [0:0] S_COUNT = TDC_COUNT;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [OUT_WIDTH-1:0] MAX_L      = {OUT_WIDTH{1'b1}};
    localparam logic [OUT_WIDTH-1:0] ZERO_L     = {OUT_WIDTH{1'b0}};
    localparam logic [TCNT_W-1:0]    TCNT_ZERO  = {TCNT_W{1'b0}};
    localparam logic [TCNT_W-1:0]    TCNT_ONE   = {{(TCNT_W-1){1'b0}}, 1'b1};
    localparam logic [TCNT_W-1:0]    TCNT_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [OUT_WIDTH-1:0] sat_inc(input logic [OUT_WIDTH-1:0] v);
        return (v == MAX_L) ? MAX_L : v + {{(OUT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic ref_e_s, fb_e_s;
    logic same_e_s, other_e_s;

    logic [0:0]           state_q, state_d;
    logic [OUT_WIDTH-1:0] count_q, count_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic                 first_fb_q, first_fb_d;
    logic [OUT_WIDTH-1:0] mag_q, mag_d;
    logic                 lead_q, lead_d;
    logic                 valid_q, valid_d;
    logic                 slip_q, slip_d;
    logic                 timeout_q, timeout_d;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ref (
        .clk     (clk),
        .rstn    (rstn),
        .async_i (ref_in),
        .rise_o  (ref_e_s)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fb (
        .clk     (clk),
        .rstn    (rstn),
        .async_i (fb_in),
        .rise_o  (fb_e_s)
    );

    assign same_e_s  = first_fb_q ? fb_e_s  : ref_e_s;
    assign other_e_s = first_fb_q ? ref_e_s : fb_e_s;

    // FSM, measurement counters and next output values
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tcnt_d     = tcnt_q;
        first_fb_d = first_fb_q;
        mag_d      = mag_q;
        lead_d     = lead_q;
        valid_d    = 1'b0;
        slip_d     = 1'b0;
        timeout_d  = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            count_d = ZERO_L;
            tcnt_d  = TCNT_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ref_e_s && fb_e_s) begin
                        mag_d   = ZERO_L;
                        lead_d  = LEAD_FB;
                        valid_d = 1'b1;
                    end else if (ref_e_s || fb_e_s) begin
                        state_d    = S_COUNT;
                        count_d    = ZERO_L;
                        tcnt_d     = TCNT_ZERO;
                        first_fb_d = fb_e_s;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_COUNT: begin
                    // a restart right after a slip strobe cannot terminate in the very next cycle
                    if (same_e_s) begin
                        mag_d   = MAX_L;
                        lead_d  = first_fb_q ? LEAD_FB : LEAD_REF;
                        valid_d = 1'b1;
                        slip_d  = 1'b1;
                        count_d = ZERO_L;
                        tcnt_d  = TCNT_ZERO;
                    end else if (other_e_s && !valid_q) begin
                        mag_d   = sat_inc(count_q);
                        lead_d  = first_fb_q ? LEAD_FB : LEAD_REF;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else if (tcnt_q == TCNT_LAST) begin
                        mag_d     = MAX_L;
                        lead_d    = first_fb_q ? LEAD_FB : LEAD_REF;
                        valid_d   = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        count_d = sat_inc(count_q);
                        tcnt_d  = tcnt_q + TCNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = ZERO_L;
                    tcnt_d  = TCNT_ZERO;
                end
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            count_q    <= ZERO_L;
            tcnt_q     <= TCNT_ZERO;
            first_fb_q <= 1'b0;
            mag_q      <= ZERO_L;
            lead_q     <= LEAD_FB;
            valid_q    <= 1'b0;
            slip_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tcnt_q     <= tcnt_d;
            first_fb_q <= first_fb_d;
            mag_q      <= mag_d;
            lead_q     <= lead_d;
            valid_q    <= valid_d;
            slip_q     <= slip_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tdc.master_out = mag_q;
    assign tdc.lead       = lead_q;
    assign tdc.valid      = valid_q;
    assign tdc.slip       = slip_q;
    assign tdc.timeout    = timeout_q;

endmodule

// File: tb/tb_phase_tdc_detector.sv
// Directed bench for phase_tdc_detector: pin-level edge patterns with hand-computed
// magnitudes, strobes captured by a monitor and compared through check_eq.
module tb_phase_tdc_detector;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic enable = 1'b1;
    logic ref_in = 1'b0;
    logic fb_in = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int mag;
        int lead;
        int slip;
        int to;
    } strobe_t;

    strobe_t strobes[$];
    logic    prev_valid = 1'b0;

    phase_tdc_detector_if #(.OUT_WIDTH(8)) bus ();

    phase_tdc_detector #(
        .OUT_WIDTH      (8),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (1023)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .enable (enable),
        .ref_in (ref_in),
        .fb_in  (fb_in),
        .tdc    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // strobe monitor, sampled 1 time unit after each active edge
    always @(posedge clk) begin
        strobe_t s;
        #1;
        if (bus.valid === 1'b1) begin
            check_eq("no_back_to_back_valid", {31'd0, prev_valid}, 32'd0);
            s.mag  = int'(bus.master_out);
            s.lead = int'(bus.lead);
            s.slip = int'(bus.slip);
            s.to   = int'(bus.timeout);
            strobes.push_back(s);
        end else if ((bus.slip | bus.timeout) !== 1'b0) begin
            check_eq("flag_without_valid", {30'd0, bus.slip, bus.timeout}, 32'd0);
        end
        prev_valid = (bus.valid === 1'b1);
    end

    task automatic expect_count(input string tag, input int n);
        check_eq({tag, "_count"}, strobes.size(), n);
    endtask

    task automatic expect_strobe(input string tag, input int mag, input int lead,
                                 input int slip, input int to);
        strobe_t s;
        if (strobes.size() > 0) begin
            s = strobes.pop_front();
        end else begin
            s.mag = -1; s.lead = -1; s.slip = -1; s.to = -1;
        end
        check_eq({tag, "_mag"},  s.mag,  mag);
        check_eq({tag, "_lead"}, s.lead, lead);
        check_eq({tag, "_slip"}, s.slip, slip);
        check_eq({tag, "_to"},   s.to,   to);
    endtask

    // first pin rises, the other rises gap cycles later (gap 0 = same cycle)
    task automatic drive_pair(input bit first_fb, input int gap);
        @(negedge clk);
        if (gap == 0) begin
            ref_in = 1'b1;
            fb_in  = 1'b1;
        end else begin
            if (first_fb) fb_in = 1'b1; else ref_in = 1'b1;
            repeat (gap) @(negedge clk);
            if (first_fb) ref_in = 1'b1; else fb_in = 1'b1;
        end
        repeat (4) @(negedge clk);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  found;

        repeat (3) @(negedge clk);
        check_eq("rst_master_out", bus.master_out, 32'd0);
        check_eq("rst_lead",       bus.lead,       32'd1);
        check_eq("rst_valid",      bus.valid,      32'd0);
        check_eq("rst_slip",       bus.slip,       32'd0);
        check_eq("rst_timeout",    bus.timeout,    32'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        drive_pair(1'b0, 5);
        expect_count("ref_fb5", 1);
        expect_strobe("ref_fb5", 5, 0, 0, 0);

        drive_pair(1'b1, 12);
        expect_count("fb_ref12", 1);
        expect_strobe("fb_ref12", 12, 1, 0, 0);
        repeat (20) @(negedge clk);
        check_eq("hold_master_out", bus.master_out, 32'd12);
        check_eq("hold_lead",       bus.lead,       32'd1);
        expect_count("hold_quiet", 0);

        drive_pair(1'b0, 0);
        expect_count("same_cycle", 1);
        expect_strobe("same_cycle", 0, 1, 0, 0);

        drive_pair(1'b0, 300);
        expect_count("sat300", 1);
        expect_strobe("sat300", 255, 0, 0, 0);

        drive_pair(1'b1, 254);
        expect_strobe("gap254", 254, 1, 0, 0);

        drive_pair(1'b0, 1);
        expect_strobe("gap1", 1, 0, 0, 0);

        // same input twice: slip restarts the measurement
        @(negedge clk);
        ref_in = 1'b1;
        repeat (3) @(negedge clk);
        ref_in = 1'b0;
        repeat (37) @(negedge clk);
        ref_in = 1'b1;
        repeat (7) @(negedge clk);
        fb_in = 1'b1;
        repeat (4) @(negedge clk);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (10) @(negedge clk);
        expect_count("slip", 2);
        expect_strobe("slip_first", 255, 0, 1, 0);
        expect_strobe("slip_second", 7, 0, 0, 0);

        // missing second edge: pin to strobe = 3 sync/detect + 1023 + 1 output
        @(negedge clk);
        ref_in = 1'b1;
        n = 0;
        found = 1'b0;
        while (!found && n < 1100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.valid === 1'b1) found = 1'b1;
        end
        check_eq("timeout_latency", n, 32'd1027);
        @(negedge clk);
        expect_count("timeout", 1);
        expect_strobe("timeout", 255, 0, 0, 1);
        ref_in = 1'b0;
        repeat (5) @(negedge clk);
        drive_pair(1'b1, 3);
        expect_strobe("after_timeout", 3, 1, 0, 0);

        // enable low mid-measurement: no strobe, outputs hold, no false edge
        drive_pair(1'b0, 9);
        expect_strobe("pre_enable", 9, 0, 0, 0);
        @(negedge clk);
        ref_in = 1'b1;
        repeat (6) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        fb_in = 1'b1;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        expect_count("enable_abort", 0);
        check_eq("enable_hold_mag",  bus.master_out, 32'd9);
        check_eq("enable_hold_lead", bus.lead,       32'd0);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (5) @(negedge clk);
        drive_pair(1'b1, 20);
        expect_strobe("after_enable", 20, 1, 0, 0);

        // reset mid-measurement: no strobe, outputs back to reset values
        @(negedge clk);
        ref_in = 1'b1;
        repeat (6) @(negedge clk);
        rstn   = 1'b0;
        ref_in = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        expect_count("reset_abort", 0);
        check_eq("reset_mid_mag",   bus.master_out, 32'd0);
        check_eq("reset_mid_lead",  bus.lead,       32'd1);
        check_eq("reset_mid_valid", bus.valid,      32'd0);
        drive_pair(1'b0, 17);
        expect_strobe("after_reset", 17, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
